atan_sched: RTL and testbench

ATAN_SCHED -- requirements
Module: atan_sched

---
 rtl/atan_sched.sv | 133 +++++++++++++
 tb/tb_atan_sched.sv | 194 +++++++++++++++++++
 2 files changed

// File: rtl/atan_sched.sv
// rtl/atan_sched.sv - two-requester round-robin scheduler for a shared combinational atan LUT
// Optional ATAN_SCHED_STATS_EN adds saturating grant/conflict counters.
module atan_sched #(
    parameter int INPUT_WIDTH  = 16,
    parameter int OUTPUT_WIDTH = 16
) (
    input  logic                    clk_i,
    input  logic                    reset_ni,
    input  logic                    clear_i,
    input  logic [INPUT_WIDTH-1:0]  req0_arg_i,
    input  logic [INPUT_WIDTH-1:0]  req1_arg_i,
    input  logic                    req0_valid_i,
    input  logic                    req1_valid_i,
    output logic                    req0_ready_o,
    output logic                    req1_ready_o,
    output logic [OUTPUT_WIDTH-1:0] req0_angle_o,
    output logic [OUTPUT_WIDTH-1:0] req1_angle_o,
    output logic                    req0_valid_o,
    output logic                    req1_valid_o,
    output logic [INPUT_WIDTH-1:0]  lut_arg_o,
    input  logic [OUTPUT_WIDTH-1:0] lut_angle_i,
    output logic                    busy_o
`ifdef ATAN_SCHED_STATS_EN
    ,
    output logic [15:0]             grant0_cnt_o,
    output logic [15:0]             grant1_cnt_o,
    output logic [15:0]             conflict_cnt_o
`endif
);

    logic                    last_q, last_d;
    logic [INPUT_WIDTH-1:0]  lut_arg_q, lut_arg_d;
    logic                    s1_valid_q, s1_valid_d;
    logic                    s1_id_q, s1_id_d;
    logic [OUTPUT_WIDTH-1:0] angle0_q, angle0_d;
    logic [OUTPUT_WIDTH-1:0] angle1_q, angle1_d;
    logic                    valid0_q, valid0_d;
    logic                    valid1_q, valid1_d;
    logic                    gnt0, gnt1, xfer;

    // last_q = 1 means requester 1 was granted last, so requester 0 wins the next conflict
    always_comb begin
        gnt0 = 1'b0;
        gnt1 = 1'b0;
        if (reset_ni && !clear_i) begin
            if (req0_valid_i && req1_valid_i) begin
                gnt0 = last_q;
                gnt1 = !last_q;
            end else begin
                gnt0 = req0_valid_i;
                gnt1 = req1_valid_i;
            end
        end
        xfer = gnt0 | gnt1;
    end

    always_comb begin
        last_d     = xfer ? gnt1 : last_q;
        lut_arg_d  = lut_arg_q;
        if (xfer) begin
            lut_arg_d = gnt1 ? req1_arg_i : req0_arg_i;
        end
        s1_valid_d = xfer;
        s1_id_d    = xfer ? gnt1 : s1_id_q;
        valid0_d   = s1_valid_q && !clear_i && !s1_id_q;
        valid1_d   = s1_valid_q && !clear_i && s1_id_q;
        angle0_d   = valid0_d ? lut_angle_i : angle0_q;
        angle1_d   = valid1_d ? lut_angle_i : angle1_q;
    end

    always_ff @(posedge clk_i or negedge reset_ni) begin
        if (!reset_ni) begin
            last_q     <= 1'b1;
            lut_arg_q  <= '0;
            s1_valid_q <= 1'b0;
            s1_id_q    <= 1'b0;
            angle0_q   <= '0;
            angle1_q   <= '0;
            valid0_q   <= 1'b0;
            valid1_q   <= 1'b0;
        end else begin
            last_q     <= last_d;
            lut_arg_q  <= lut_arg_d;
            s1_valid_q <= s1_valid_d;
            s1_id_q    <= s1_id_d;
            angle0_q   <= angle0_d;
            angle1_q   <= angle1_d;
            valid0_q   <= valid0_d;
            valid1_q   <= valid1_d;
        end
    end

    assign req0_ready_o = gnt0;
    assign req1_ready_o = gnt1;
    assign req0_angle_o = angle0_q;
    assign req1_angle_o = angle1_q;
    assign req0_valid_o = valid0_q;
    assign req1_valid_o = valid1_q;
    assign lut_arg_o    = lut_arg_q;
    assign busy_o       = s1_valid_q | valid0_q | valid1_q;

`ifdef ATAN_SCHED_STATS_EN
    logic [15:0] g0_cnt_q, g0_cnt_d;
    logic [15:0] g1_cnt_q, g1_cnt_d;
    logic [15:0] cf_cnt_q, cf_cnt_d;
    logic        conflict;

    // Counters ignore clear_i; they saturate rather than wrap
    always_comb begin
        conflict = req0_valid_i && req1_valid_i;
        g0_cnt_d = (gnt0 && g0_cnt_q != 16'hFFFF) ? g0_cnt_q + 16'd1 : g0_cnt_q;
        g1_cnt_d = (gnt1 && g1_cnt_q != 16'hFFFF) ? g1_cnt_q + 16'd1 : g1_cnt_q;
        cf_cnt_d = (conflict && cf_cnt_q != 16'hFFFF) ? cf_cnt_q + 16'd1 : cf_cnt_q;
    end

    always_ff @(posedge clk_i or negedge reset_ni) begin
        if (!reset_ni) begin
            g0_cnt_q <= '0;
            g1_cnt_q <= '0;
            cf_cnt_q <= '0;
        end else begin
            g0_cnt_q <= g0_cnt_d;
            g1_cnt_q <= g1_cnt_d;
            cf_cnt_q <= cf_cnt_d;
        end
    end

    assign grant0_cnt_o   = g0_cnt_q;
    assign grant1_cnt_o   = g1_cnt_q;
    assign conflict_cnt_o = cf_cnt_q;
`endif

endmodule

// File: tb/tb_atan_sched.sv
// tb/tb_atan_sched.sv - scoreboard bench for atan_sched with a behavioural LUT
// Also checks the ATAN_SCHED_STATS_EN counters when that macro is defined.
module tb_atan_sched;

    logic        clk = 1'b0;
    logic        reset_ni;
    logic        clear_i;
    logic [15:0] a0, a1;
    logic        v0, v1;
    logic        ready0, ready1;
    logic [15:0] angle0, angle1;
    logic        valid0, valid1;
    logic [15:0] lut_arg, lut_angle;
    logic        busy;
`ifdef ATAN_SCHED_STATS_EN
    logic [15:0] g0_cnt, g1_cnt, cf_cnt;
`endif

    always #5 clk = ~clk;

    atan_sched #(.INPUT_WIDTH(16), .OUTPUT_WIDTH(16)) dut (
        .clk_i(clk), .reset_ni(reset_ni), .clear_i(clear_i),
        .req0_arg_i(a0), .req1_arg_i(a1),
        .req0_valid_i(v0), .req1_valid_i(v1),
        .req0_ready_o(ready0), .req1_ready_o(ready1),
        .req0_angle_o(angle0), .req1_angle_o(angle1),
        .req0_valid_o(valid0), .req1_valid_o(valid1),
        .lut_arg_o(lut_arg), .lut_angle_i(lut_angle), .busy_o(busy)
`ifdef ATAN_SCHED_STATS_EN
        , .grant0_cnt_o(g0_cnt), .grant1_cnt_o(g1_cnt), .conflict_cnt_o(cf_cnt)
`endif
    );

    function automatic logic [15:0] lut_f(input logic [15:0] x);
        return {x[0], x[15:1]} ^ (x >> 3);
    endfunction

    assign lut_angle = lut_f(lut_arg);

    typedef struct {
        bit          id;
        logic [15:0] ang;
        int          due;
    } res_t;

    res_t        sb[$];
    int          cyc = 0;
    int          n_tests = 0;
    int          n_fail = 0;
    bit          m_last = 1'b1;
    logic [15:0] m_lut = '0, m_ang0 = '0, m_ang1 = '0;
    int          m_c0 = 0, m_c1 = 0, m_cc = 0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    task automatic check_cycle();
        bit   g0, g1, e0, e1, eb;
        res_t r;
        g0 = 1'b0;
        g1 = 1'b0;
        if (reset_ni && !clear_i) begin
            if (v0 && v1) begin
                g0 = m_last;
                g1 = !m_last;
            end else begin
                g0 = v0;
                g1 = v1;
            end
        end
        chk("ready0", ready0, g0);
        chk("ready1", ready1, g1);
        e0 = 1'b0;
        e1 = 1'b0;
        if (!reset_ni) begin
            sb.delete();
            m_ang0 = '0; m_ang1 = '0; m_lut = '0; m_last = 1'b1;
            m_c0 = 0; m_c1 = 0; m_cc = 0;
        end else if (sb.size() > 0 && sb[0].due == cyc) begin
            r = sb.pop_front();
            if (r.id) begin e1 = 1'b1; m_ang1 = r.ang; end
            else      begin e0 = 1'b1; m_ang0 = r.ang; end
        end
        eb = e0 | e1 | (sb.size() > 0 && sb[0].due == cyc + 1);
        chk("valid0", valid0, e0);
        chk("valid1", valid1, e1);
        chk("angle0", angle0, m_ang0);
        chk("angle1", angle1, m_ang1);
        chk("busy", busy, eb);
        chk("lut_arg", lut_arg, m_lut);
`ifdef ATAN_SCHED_STATS_EN
        chk("grant0_cnt", g0_cnt, m_c0);
        chk("grant1_cnt", g1_cnt, m_c1);
        chk("conflict_cnt", cf_cnt, m_cc);
`endif
        if (reset_ni) begin
            if (clear_i) begin
                sb.delete();
            end else if (g0 | g1) begin
                sb.push_back('{g1, lut_f(g1 ? a1 : a0), cyc + 2});
                m_lut  = g1 ? a1 : a0;
                m_last = g1;
            end
            if (g0 && m_c0 < 65535) m_c0++;
            if (g1 && m_c1 < 65535) m_c1++;
            if (v0 && v1 && m_cc < 65535) m_cc++;
        end
    endtask

    task automatic step(input bit rv0, input logic [15:0] ra0,
                        input bit rv1, input logic [15:0] ra1, input bit clr);
        v0 = rv0; a0 = ra0; v1 = rv1; a1 = ra1; clear_i = clr;
        @(negedge clk);
        check_cycle();
        @(posedge clk);
        #1;
        cyc++;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(0, 16'h0, 0, 16'h0, 0);
    endtask

    initial begin
        reset_ni = 1'b0; clear_i = 1'b0;
        v0 = 1'b0; v1 = 1'b0; a0 = '0; a1 = '0;
        step(1, 16'h1111, 1, 16'h2222, 0);
        step(0, 16'h0, 0, 16'h0, 0);
        reset_ni = 1'b1;
        idle(1);

        // single requester 0, then idle to see the strobe two cycles later
        step(1, 16'h8000, 0, 16'h0, 0);
        idle(3);
        chk("angle0_8000", angle0, lut_f(16'h8000));

        // continuous conflict: alternate grants, back-to-back results
        for (int i = 0; i < 6; i++) step(1, 16'h0100 + i, 1, 16'h0A00 + i, 0);
        idle(3);

        // requester 1 back to back with boundary arguments
        step(0, 16'h0, 1, 16'h0000, 0);
        step(0, 16'h0, 1, 16'hFFFF, 0);
        idle(3);
        chk("angle1_ffff", angle1, lut_f(16'hFFFF));

        // clear the cycle after a transfer, with a colliding request that must not be taken
        step(1, 16'h4321, 0, 16'h0, 0);
        step(1, 16'h5555, 1, 16'h6666, 1);
        step(1, 16'h5555, 1, 16'h6666, 0);
        idle(3);

        // requester 1 changes its argument while being held off
        for (int i = 0; i < 4; i++) step(1, 16'h7000 + i, 1, 16'h9000 + 16'(i * 7), 0);
        idle(3);

        // asynchronous reset with a lookup in flight
        step(1, 16'h1234, 0, 16'h0, 0);
        reset_ni = 1'b0;
        v0 = 1'b1;
        #1;
        chk("rst_lut_arg", lut_arg, 0);
        chk("rst_valid0", valid0, 0);
        chk("rst_angle0", angle0, 0);
        chk("rst_busy", busy, 0);
        chk("rst_ready0", ready0, 0);
        step(1, 16'h1234, 1, 16'h4444, 0);
        reset_ni = 1'b1;
        step(1, 16'hAAAA, 1, 16'hBBBB, 0);
        chk("first_conflict_req0", sb[sb.size()-1].id, 0);
        for (int i = 0; i < 3; i++) step(1, 16'hAAAA, 1, 16'hBBBB, 0);
        idle(3);
`ifdef ATAN_SCHED_STATS_EN
        chk("stats_g0", g0_cnt, 2);
        chk("stats_g1", g1_cnt, 2);
        chk("stats_cf", cf_cnt, 4);
`endif

        for (int i = 0; i < 150; i++) begin
            step(1'($urandom_range(0, 1)), 16'($urandom), 1'($urandom_range(0, 1)),
                 16'($urandom), ($urandom_range(0, 15) == 0));
        end
        idle(3);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
